// File: rtl/idu_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// idu_pipe_ctrl
//   Pipeline control for the ID->EX pipe register. Merges fetch redirect
//   requests (trap > jump > fence) with decode/EX hazard stalls into a single
//   stall/flush bus, holds the flush for FLUSH_CYCLES cycles per redirect and
//   drains outstanding memory traffic before completing a fence.
//
// Parameters
//   FLUSH_CYCLES     cycles the flush bit is held per redirect (1..15)
//   WDT_LIMIT        consecutive stall cycles before the watchdog fires
//
// Optional feature
//   IDU_PIPE_CTRL_WDT_EN  when defined, builds the stall watchdog; otherwise
//                         stall_timeout_o is tied 0.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   trap_req_i/addr     exception/interrupt redirect
//   jump_req_i/addr     EX branch/jump redirect
//   fence_req_i/pc      fence in EX and its PC
//   lsu_idle_i          no outstanding memory transactions
//   load_use_i, agu_busy_i, ex_busy_i   hazard inputs
//   stall_flag_o        stall/flush bus (CU_FLUSH, CU_STALL, CU_AGU_STALL)
//   redirect_valid_o/addr_o  fetch redirect strobe and target
//   fence_ack_o         one-cycle pulse when a fence completes
//   stall_timeout_o     watchdog pulse
// -----------------------------------------------------------------------------
`ifndef CU_BUS_WIDTH
`define CU_BUS_WIDTH 8
`endif
`ifndef CU_FLUSH
`define CU_FLUSH 0
`endif
`ifndef CU_STALL
`define CU_STALL 1
`endif
`ifndef CU_AGU_STALL
`define CU_AGU_STALL 2
`endif

module idu_pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WDT_LIMIT    = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trap_req_i,
    input  logic [31:0]              trap_addr_i,
    input  logic                     jump_req_i,
    input  logic [31:0]              jump_addr_i,
    input  logic                     fence_req_i,
    input  logic [31:0]              fence_pc_i,
    input  logic                     lsu_idle_i,
    input  logic                     load_use_i,
    input  logic                     agu_busy_i,
    input  logic                     ex_busy_i,
    output logic [`CU_BUS_WIDTH-1:0] stall_flag_o,
    output logic                     redirect_valid_o,
    output logic [31:0]              redirect_addr_o,
    output logic                     fence_ack_o,
    output logic                     stall_timeout_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_FENCE_FL = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_fence_tgt;

    logic        w_flush;
    logic        w_stall;
    logic        w_agu;
    logic        w_redirect;
    logic [31:0] w_addr;
    logic        w_ack;
    logic        w_new_redir;   // trap/jump accepted this cycle
    logic        w_fence_start; // fence accepted from RUN this cycle

    always_comb begin
        w_flush       = 1'b0;
        w_stall       = 1'b0;
        w_agu         = 1'b0;
        w_redirect    = 1'b0;
        w_addr        = 32'd0;
        w_ack         = 1'b0;
        w_new_redir   = 1'b0;
        w_fence_start = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (trap_req_i || jump_req_i) begin
                    w_new_redir = 1'b1;
                    w_flush     = 1'b1;
                    w_redirect  = 1'b1;
                    w_addr      = trap_req_i ? trap_addr_i : jump_addr_i;
                end else if (fence_req_i) begin
                    w_fence_start = 1'b1;
                    w_stall       = 1'b1;
                end else begin
                    w_stall = load_use_i | ex_busy_i;
                    w_agu   = agu_busy_i;
                end
            end
            ST_FLUSH: begin
                w_flush = 1'b1;
                if (trap_req_i || jump_req_i) begin
                    w_new_redir = 1'b1;
                    w_redirect  = 1'b1;
                    w_addr      = trap_req_i ? trap_addr_i : jump_addr_i;
                end
            end
            ST_DRAIN: begin
                // Jumps are ignored here; only a trap may abort the fence.
                if (trap_req_i) begin
                    w_new_redir = 1'b1;
                    w_flush     = 1'b1;
                    w_redirect  = 1'b1;
                    w_addr      = trap_addr_i;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin // ST_FENCE_FL
                w_flush    = 1'b1;
                w_redirect = 1'b1;
                if (trap_req_i) begin
                    w_new_redir = 1'b1;
                    w_addr      = trap_addr_i;
                end else begin
                    w_addr = r_fence_tgt;
                    w_ack  = 1'b1;
                end
            end
        endcase
        // A flush must always load the bubble, so it overrides any stall.
        if (w_flush) begin
            w_stall = 1'b0;
            w_agu   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cnt       <= 4'd0;
            r_fence_tgt <= 32'd0;
        end else if (w_new_redir) begin
            if (FLUSH_CYCLES > 1) begin
                r_state <= ST_FLUSH;
                r_cnt   <= FLUSH_RELOAD;
            end else begin
                r_state <= ST_RUN;
                r_cnt   <= 4'd0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_fence_start) begin
                        r_state     <= ST_DRAIN;
                        r_fence_tgt <= fence_pc_i + 32'd4;
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt <= 4'd1) begin
                        r_state <= ST_RUN;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DRAIN: begin
                    if (lsu_idle_i) begin
                        r_state <= ST_FENCE_FL;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is held.
    always_comb begin
        stall_flag_o                = '0;
        stall_flag_o[`CU_FLUSH]     = w_flush & ~rst;
        stall_flag_o[`CU_STALL]     = w_stall & ~rst;
        stall_flag_o[`CU_AGU_STALL] = w_agu & ~rst;
    end
    assign redirect_valid_o = w_redirect & ~rst;
    assign redirect_addr_o  = rst ? 32'd0 : w_addr;
    assign fence_ack_o      = w_ack & ~rst;

`ifdef IDU_PIPE_CTRL_WDT_EN
    localparam logic [15:0] WDT_LAST = 16'(WDT_LIMIT - 1);

    logic [15:0] r_wdt_cnt;
    logic        r_wdt_fired;  // blocks re-pulsing within one stall run
    logic        w_stall_any;

    assign w_stall_any = (w_stall | w_agu) & ~w_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdt_cnt   <= 16'd0;
            r_wdt_fired <= 1'b0;
        end else if (!w_stall_any) begin
            r_wdt_cnt   <= 16'd0;
            r_wdt_fired <= 1'b0;
        end else if (r_wdt_cnt == WDT_LAST) begin
            r_wdt_fired <= 1'b1;
        end else begin
            r_wdt_cnt <= r_wdt_cnt + 16'd1;
        end
    end

    assign stall_timeout_o = w_stall_any & (r_wdt_cnt == WDT_LAST) & ~r_wdt_fired & ~rst;
`else
    assign stall_timeout_o = 1'b0;
`endif

endmodule

// File: doc/idu_pipe_ctrl.md
Name: idu_pipe_ctrl

Overview:
- Pipeline control unit that sequences the ID→EX pipe register.
- Merges redirect requests (trap, jump mispredict, fence) with hazard stalls (load-use, AGU, multi-cycle EX) into the `CU_BUS_WIDTH` stall/flush bus.
- Arbitrates redirect sources, holds flush for a programmable window and drains the pipeline for fences.
- Sits beside the decode stage; drives stall_flag of the ID/EX pipe and the fetch redirect.

Parameters:
- FLUSH_CYCLES, 1, cycles flush is held per redirect (legal 1..15).
- WDT_LIMIT, 1024, consecutive-stall cycles before watchdog fires (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- trap_req_i  in  1  exception/interrupt redirect request
- trap_addr_i  in  32  trap target
- jump_req_i  in  1  EX branch/jump redirect request
- jump_addr_i  in  32  jump target
- fence_req_i  in  1  fence/fence.i in EX
- fence_pc_i  in  32  PC of the fence instruction
- lsu_idle_i  in  1  no outstanding memory transactions
- load_use_i  in  1  load-use hazard in decode
- agu_busy_i  in  1  AGU cannot accept
- ex_busy_i  in  1  multi-cycle EX unit busy
- stall_flag_o  out  `CU_BUS_WIDTH  bits `CU_FLUSH, `CU_STALL, `CU_AGU_STALL; all other bits 0
- redirect_valid_o  out  1  fetch redirect strobe
- redirect_addr_o  out  32  fetch redirect target
- fence_ack_o  out  1  one-cycle pulse when fence completes
- stall_timeout_o  out  1  watchdog pulse (0 when feature is compiled out)

Behaviour:
- Reset: state RUN, flush counter 0, captured fence target 0. All outputs 0 while rst is high and in the cycle after deassertion until an input requests otherwise.
- FSM states: RUN, FLUSH, DRAIN, FENCE_FL.
- Redirect priority in the same cycle: trap > jump > fence.
- RUN:
  - trap_req_i or jump_req_i: combinationally, in the same cycle, assert `CU_FLUSH`, redirect_valid_o=1, and redirect_addr_o=winner's address.
  - If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  - fence_req_i (no trap/jump): capture fence_pc_i+4 (mod 2^32 wrap) and go to DRAIN. `CU_STALL` is asserted in this cycle.
  - No request:
    - `CU_STALL` = load_use_i | ex_busy_i.
    - `CU_AGU_STALL` = agu_busy_i.
    - redirect outputs 0.
- FLUSH:
  - `CU_FLUSH`=1 and redirect_valid_o=0.
  - Counter decrements; return to RUN when it reaches 0 (leave on the cycle counter==1).
  - A new trap/jump in FLUSH re-issues the redirect the same cycle and reloads the counter.
- DRAIN:
  - `CU_STALL`=1.
  - When lsu_idle_i=1, go to FENCE_FL.
  - A trap in DRAIN aborts the fence with no fence_ack_o, and is handled exactly as in RUN.
  - jump_req_i is ignored in DRAIN.
- FENCE_FL (1 cycle):
  - `CU_FLUSH`=1, redirect_valid_o=1, redirect_addr_o=captured target, fence_ack_o=1.
  - Next state RUN.
  - A trap in this cycle wins: the trap address is driven and fence_ack_o=0.
- Flush dominance: whenever `CU_FLUSH`=1, `CU_STALL` and `CU_AGU_STALL` are forced 0. This guarantees the ID/EX register loads the bubble.
- Hazard inputs are ignored outside RUN, except that `CU_STALL` is held in DRAIN.
- Asynchronous reset mid-operation (any state) returns to RUN immediately and clears the counters; no pending redirect survives.

Optional Feature:
- Macro: IDU_PIPE_CTRL_WDT_EN.
- Defined:
  - A 16-bit counter increments on every cycle where `CU_STALL` or `CU_AGU_STALL` is 1 and `CU_FLUSH` is 0.
  - It clears on any cycle without a stall.
  - When it equals WDT_LIMIT-1 and a stall is still asserted, stall_timeout_o pulses for 1 cycle and the counter saturates. It does not re-pulse until a stall-free cycle occurs.
- Undefined: the counter is absent and stall_timeout_o is tied 0.

Test Plan:
- Reset then idle: rst pulse, no requests → stall_flag_o=0, redirect_valid_o=0, redirect_addr_o=0.
- Simultaneous trap_req_i(0x8000_0100) and jump_req_i(0x8000_2000), FLUSH_CYCLES=3 → same cycle redirect_addr_o=0x8000_0100; `CU_FLUSH` high exactly 3 cycles; redirect_valid_o high only the first.
- load_use_i=1 with agu_busy_i=1 in RUN → `CU_STALL`=1 and `CU_AGU_STALL`=1. Then jump_req_i asserted as well → `CU_FLUSH`=1 with both stall bits 0.
- fence_req_i at fence_pc_i=0x0000_0FFC, lsu_idle_i low for 4 cycles → `CU_STALL` for 5 cycles, then a 1-cycle flush with redirect 0x0000_1000 and fence_ack_o=1. Also fence_pc_i=0xFFFF_FFFC → target 0x0000_0000.
- Trap during DRAIN → immediate trap redirect, no fence_ack_o, FSM leaves DRAIN.
- IDU_PIPE_CTRL_WDT_EN, WDT_LIMIT=8, ex_busy_i held 10 cycles → stall_timeout_o pulses once on the 8th stall cycle. Deassert 1 cycle and reassert 8 cycles → pulses again.
